// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: ALU ctrl encodings, memory-stage states and the write-back record.
package mips_pkg;

    localparam logic [3:0] CTRL_ADDIU = 4'b0000;
    localparam logic [3:0] CTRL_SW    = 4'b0001;
    localparam logic [3:0] CTRL_ADDU  = 4'b0010;
    localparam logic [3:0] CTRL_JAL   = 4'b0011;
    localparam logic [3:0] CTRL_LW    = 4'b0100;
    localparam logic [3:0] CTRL_OR    = 4'b0101;
    localparam logic [3:0] CTRL_BNE   = 4'b0110;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        reg_write;
        logic        misaligned;
        logic        bus_err;
    } wb_rec_t;

endpackage

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU results through, or runs a req/ack
// data-memory transaction for lw/sw, delivering one registered write-back record per op.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_ctrl,
    input  logic [31:0]       in_result,
    input  logic [31:0]       in_store_data,
    input  logic [4:0]        in_dest,
    input  logic              in_reg_write,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [4:0]        out_dest,
    output logic              out_reg_write,
    output logic              out_misaligned,
    output logic              out_bus_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [4:0]        wait_dest_q, wait_dest_d;
    logic              wait_reg_write_q, wait_reg_write_d;
    logic              out_valid_q, out_valid_d;
    wb_rec_t           rec_q, rec_d;

    logic is_mem_op;
    logic accept;

    // in_ready is forced low while reset is asserted, not just after it.
    assign in_ready  = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mem_op = (in_ctrl == CTRL_LW) || (in_ctrl == CTRL_SW);

    // NOTE: every signal assigned in this block gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        mem_req_d        = mem_req_q;
        mem_we_d         = mem_we_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        wait_dest_d      = wait_dest_q;
        wait_reg_write_d = wait_reg_write_q;
        out_valid_d      = out_valid_q;
        rec_d            = rec_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_mem_op) begin
                        out_valid_d = 1'b1;
                        rec_d       = '{data: in_result, dest: in_dest, reg_write: in_reg_write,
                                        misaligned: 1'b0, bus_err: 1'b0};
                    end else if (in_result[1:0] != 2'b00) begin
                        out_valid_d = 1'b1;
                        rec_d       = '{data: in_result, dest: in_dest, reg_write: 1'b0,
                                        misaligned: 1'b1, bus_err: 1'b0};
                    end else begin
                        state_d          = MEM_WAIT;
                        cnt_d            = '0;
                        mem_req_d        = 1'b1;
                        mem_we_d         = (in_ctrl == CTRL_SW);
                        mem_addr_d       = ADDR_W'(in_result);
                        mem_wdata_d      = in_store_data;
                        wait_dest_d      = in_dest;
                        wait_reg_write_d = in_reg_write;
                    end
                end
            end

            MEM_WAIT: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    rec_d       = '{data:       mem_we_q ? 32'(mem_addr_q) : mem_rdata,
                                    dest:       wait_dest_q,
                                    reg_write:  mem_we_q ? 1'b0 : wait_reg_write_q,
                                    misaligned: 1'b0,
                                    bus_err:    1'b0};
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_LIMIT)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    rec_d       = '{data: 32'(mem_addr_q), dest: wait_dest_q, reg_write: 1'b0,
                                    misaligned: 1'b0, bus_err: 1'b1};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            wait_dest_q      <= '0;
            wait_reg_write_q <= 1'b0;
            out_valid_q      <= 1'b0;
            rec_q            <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            mem_req_q        <= mem_req_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            wait_dest_q      <= wait_dest_d;
            wait_reg_write_q <= wait_reg_write_d;
            out_valid_q      <= out_valid_d;
            rec_q            <= rec_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign out_valid      = out_valid_q;
    assign out_data       = rec_q.data;
    assign out_dest       = rec_q.dest;
    assign out_reg_write  = rec_q.reg_write;
    assign out_misaligned = rec_q.misaligned;
    assign out_bus_err    = rec_q.bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: pass-through, lw/sw with ack,
// misalignment, timeout, reset during wait, output back-pressure and back-to-back issue.
module tb_mem_access_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic [31:0] in_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_dest;
    logic        in_reg_write;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_dest;
    logic        out_reg_write;
    logic        out_misaligned;
    logic        out_bus_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int req_cycles;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ctrl       (in_ctrl),
        .in_result     (in_result),
        .in_store_data (in_store_data),
        .in_dest       (in_dest),
        .in_reg_write  (in_reg_write),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_dest      (out_dest),
        .out_reg_write (out_reg_write),
        .out_misaligned(out_misaligned),
        .out_bus_err   (out_bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] ctrl, input logic [31:0] res,
                            input logic [31:0] sdata, input logic [4:0] dest, input logic rw);
        in_valid      = 1'b1;
        in_ctrl       = ctrl;
        in_result     = res;
        in_store_data = sdata;
        in_dest       = dest;
        in_reg_write  = rw;
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_ctrl       = CTRL_ADDU;
        in_result     = '0;
        in_store_data = '0;
        in_dest       = '0;
        in_reg_write  = 1'b0;
        mem_rdata     = '0;
        mem_ack       = 1'b0;
        out_ready     = 1'b1;

        // Reset state
        #3;
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_mem_req",   mem_req,   0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 1);

        // addu pass-through, latency 1
        drive_op(CTRL_ADDU, 32'h0000_0010, 32'h0, 5'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        check("addu_valid",   out_valid,      1);
        check("addu_data",    out_data,       32'h10);
        check("addu_dest",    out_dest,       5);
        check("addu_rw",      out_reg_write,  1);
        check("addu_mis",     out_misaligned, 0);
        check("addu_no_req",  mem_req,        0);

        // lw with ack in the third request cycle
        drive_op(CTRL_LW, 32'h0000_0100, 32'h0, 5'd8, 1'b1);
        tick();
        in_valid = 1'b0;
        check("lw_req1",      mem_req,   1);
        check("lw_we",        mem_we,    0);
        check("lw_addr",      mem_addr,  32'h100);
        check("lw_out_valid", out_valid, 0);
        check("lw_ready1",    in_ready,  0);
        tick();
        check("lw_req2",      mem_req,   1);
        check("lw_addr2",     mem_addr,  32'h100);
        check("lw_ready2",    in_ready,  0);
        tick();
        check("lw_req3",      mem_req,   1);
        check("lw_ready3",    in_ready,  0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check("lw_req_drop",  mem_req,       0);
        check("lw_valid",     out_valid,     1);
        check("lw_data",      out_data,      32'hDEAD_BEEF);
        check("lw_dest",      out_dest,      8);
        check("lw_rw",        out_reg_write, 1);

        // sw with ack in the first request cycle
        drive_op(CTRL_SW, 32'h0000_0104, 32'h1234_5678, 5'd9, 1'b0);
        tick();
        in_valid = 1'b0;
        check("sw_req",   mem_req,   1);
        check("sw_we",    mem_we,    1);
        check("sw_addr",  mem_addr,  32'h104);
        check("sw_wdata", mem_wdata, 32'h1234_5678);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sw_req_drop", mem_req,       0);
        check("sw_valid",    out_valid,     1);
        check("sw_rw",       out_reg_write, 0);
        check("sw_data",     out_data,      32'h104);

        // Misaligned lw: no memory access
        drive_op(CTRL_LW, 32'h0000_0102, 32'h0, 5'd10, 1'b1);
        tick();
        in_valid = 1'b0;
        check("mis_no_req", mem_req,        0);
        check("mis_valid",  out_valid,      1);
        check("mis_flag",   out_misaligned, 1);
        check("mis_rw",     out_reg_write,  0);
        check("mis_data",   out_data,       32'h102);

        // lw with no ack: timeout after exactly 16 request cycles
        drive_op(CTRL_LW, 32'h0000_0200, 32'h0, 5'd11, 1'b1);
        tick();
        in_valid   = 1'b0;
        req_cycles = 0;
        while (mem_req && req_cycles < 40) begin
            req_cycles++;
            tick();
        end
        check("to_req_cycles", req_cycles,     16);
        check("to_bus_err",    out_bus_err,    1);
        check("to_valid",      out_valid,      1);
        check("to_rw",         out_reg_write,  0);
        check("to_mis_clear",  out_misaligned, 0);
        check("to_in_ready",   in_ready,       1);

        // Reset in the middle of a second lw wait
        drive_op(CTRL_LW, 32'h0000_0300, 32'h0, 5'd12, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        check("rw_req_before", mem_req, 1);
        rst_n = 1'b0;
        #1;
        check("rw_req_drop",  mem_req,   0);
        check("rw_out_valid", out_valid, 0);
        check("rw_in_ready",  in_ready,  0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rw_still_idle", mem_req, 0);

        // Output back-pressure: record held, in_ready low, then same-cycle accept
        out_ready = 1'b0;
        drive_op(CTRL_OR, 32'h0000_ABCD, 32'h0, 5'd3, 1'b1);
        tick();
        drive_op(CTRL_ADDIU, 32'h0000_0055, 32'h0, 5'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_valid",    out_valid, 1);
            check("bp_data",     out_data,  32'h0000_ABCD);
            check("bp_dest",     out_dest,  3);
            check("bp_in_ready", in_ready,  0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_next_data", out_data,  32'h55);
        check("bp_next_dest", out_dest,  4);
        check("bp_next_vld",  out_valid, 1);

        // Back-to-back pass-through ops, one per cycle
        for (int i = 0; i < 3; i++) begin
            drive_op(CTRL_ADDU, 32'h0000_1000 + 32'(i), 32'h0, 5'(16 + i), 1'b1);
            #1;
            check("b2b_in_ready", in_ready, 1);
            tick();
            check("b2b_data", out_data,  32'h0000_1000 + 32'(i));
            check("b2b_dest", out_dest,  32'(16 + i));
            check("b2b_vld",  out_valid, 1);
        end
        in_valid = 1'b0;

        // Stray ack while idle is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_ack_valid", out_valid, 0);
        check("stray_ack_req",   mem_req,   0);
        tick();
        check("stray_ack_ready", in_ready,  1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Sits directly downstream of the ALU and consumes its 32-bit result together with its 4-bit ctrl code.
- For lw/sw it uses the result as a byte address and runs a req/ack transaction with data memory. All other ops pass the result through.
- Delivers one registered write-back record per accepted op, using valid/ready handshakes on both sides.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in MEM_WAIT before a bus error is reported. 0 disables the timeout.
- ADDR_W, 32: width of mem_addr. The low 32 bits come from the ALU result.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept an op this cycle
- in_ctrl  in  4  ALU ctrl code (lw=4'b0100, sw=4'b0001, others pass through)
- in_result  in  32  ALU result (address for lw/sw)
- in_store_data  in  32  rt value for sw
- in_dest  in  5  destination register
- in_reg_write  in  1  op writes a register
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  transaction complete
- out_valid  out  1  write-back record valid
- out_ready  in  1  downstream accepts record
- out_data  out  32  load data or pass-through result
- out_dest  out  5  destination register
- out_reg_write  out  1  write enable for write-back
- out_misaligned  out  1  lw/sw address[1:0] != 0
- out_bus_err  out  1  memory timeout

Behaviour:
- Reset: asynchronous on rst_n low.
  - All outputs go to 0, state goes to IDLE, timeout counter clears.
  - in_ready is 0 during reset.
  - A reset during MEM_WAIT drops mem_req immediately and the op is lost.
- States: IDLE, MEM_WAIT. All outputs are registered except in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept when in_valid && in_ready. Outcomes:
  - Non-memory ctrl: next cycle out_valid=1, out_data=in_result, out_dest/out_reg_write copied. Latency 1.
  - lw/sw with in_result[1:0]!=0: no memory access. Next cycle out_valid=1, out_misaligned=1, out_reg_write=0, out_data=in_result.
  - Aligned lw/sw: next cycle mem_req=1, mem_we=(sw), mem_addr=in_result, mem_wdata=in_store_data. State goes to MEM_WAIT and out_valid goes to 0 unless it is still held.
- MEM_WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until the cycle mem_ack=1.
  - Ack in the first req cycle is legal. Minimum lw latency is 2 cycles (accept to out_valid).
  - On ack: mem_req goes to 0 next cycle and state goes to IDLE.
  - lw on ack: out_data=mem_rdata, out_reg_write=in_reg_write (latched).
  - sw on ack: out_data=mem_addr, out_reg_write=0. out_valid=1.
- Timeout: the counter increments each MEM_WAIT cycle without ack.
  - At count == TIMEOUT_CYCLES-1 with no ack: mem_req drops, out_valid=1, out_bus_err=1, out_reg_write=0, state goes to IDLE.
  - If ack and the timeout limit occur in the same cycle, ack wins.
- mem_ack while mem_req=0 is ignored.
- Output hold: out_valid and the record stay unchanged until out_valid && out_ready. The flags (misaligned/bus_err) clear with the next record.
- Back-to-back: with out_ready=1, a pass-through op can be accepted every cycle (throughput 1).
- No new op is accepted while in MEM_WAIT.

Decomposition:
- Shared package mips_pkg holds:
  - ctrl code constants (the ALU encoding: addiu 0000, sw 0001, addu 0010, jal 0011, lw 0100, or 0101, bne 0110)
  - the mem_state_t enum {IDLE, MEM_WAIT}
  - a wb_rec_t struct (data, dest, reg_write, misaligned, bus_err)
- No sub-module. The timeout counter is inline.

Test Plan:
- addu op, in_result=32'h0000_0010, dest=5, out_ready=1 -> next cycle out_valid=1, out_data=32'h10, out_dest=5, out_reg_write=1, no mem_req.
- lw addr 32'h0000_0100, ack 3 cycles after mem_req rises with rdata=32'hDEAD_BEEF -> mem_req held 3 cycles with mem_we=0, then out_data=32'hDEADBEEF, in_ready low throughout.
- sw addr 32'h0000_0104, store_data=32'h1234_5678, ack in first req cycle -> mem_we=1, mem_wdata=32'h12345678, out_valid with out_reg_write=0, out_data=32'h104.
- lw addr 32'h0000_0102 -> no mem_req; out_valid, out_misaligned=1, out_reg_write=0.
- lw with mem_ack never asserted, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then out_bus_err=1, state IDLE, in_ready=1. Then rst_n pulse during a second lw wait -> mem_req=0 immediately, out_valid=0.
- out_ready=0 for 4 cycles after a pass-through result -> record stable, in_ready=0; out_ready=1 -> next op accepted that same cycle.
